// File: rtl/avalon_tri_pkg.sv
// Shared constants for the Avalon triangle classifier: register map,
// result word layout and the engine state encoding.
package avalon_tri_pkg;

  localparam logic [1:0] REG_A      = 2'd0;
  localparam logic [1:0] REG_B      = 2'd1;
  localparam logic [1:0] REG_C      = 2'd2;
  localparam logic [1:0] REG_RESULT = 2'd3;

  localparam logic [1:0] KIND_NONE     = 2'd0;
  localparam logic [1:0] KIND_SCALENE  = 2'd1;
  localparam logic [1:0] KIND_ISO      = 2'd2;
  localparam logic [1:0] KIND_EQUI     = 2'd3;

  localparam int RES_TRI_BIT   = 0;
  localparam int RES_KIND_LSB  = 1;
  localparam int RES_KIND_MSB  = 2;
  localparam int RES_RIGHT_BIT = 3;

  // Cycles from a dirty RESULT read being sampled to waitrequest dropping.
  localparam int ENGINE_LAT = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHK,
    ST_SQ,
    ST_DONE
  } eng_state_t;

endpackage

// File: rtl/avalon_tri_classify_core.sv
// Shared classification engine: sorts a side triple, checks the triangle
// inequality and equalities, then tests for a right angle at full width.
module tri_class_core
  import avalon_tri_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] c,
  output logic          done,
  output logic [3:0]    result
);

  eng_state_t state, state_next;

  logic [DW-1:0]   mx, lo0, lo1;
  logic [DW-1:0]   sa, sb, sc;
  logic            is_tri_q, eq_ab_q, eq_bc_q, eq_ac_q, right_q;
  logic [DW:0]     sum_ab;
  logic [2*DW:0]   ea, eb, ec, sq_sum, sq_c;
  logic [1:0]      kind;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_LOAD;
      ST_LOAD: state_next = ST_CHK;
      ST_CHK:  state_next = ST_SQ;
      ST_SQ:   state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Put the largest side in c so the inequality and Pythagoras need one form.
  always_comb begin
    mx  = c;
    lo0 = a;
    lo1 = b;
    if (a >= b && a >= c) begin
      mx  = a;
      lo0 = b;
      lo1 = c;
    end else if (b >= c) begin
      mx  = b;
      lo0 = a;
      lo1 = c;
    end
  end

  always_comb begin
    sum_ab = {1'b0, sa} + {1'b0, sb};
    ea     = {{(DW+1){1'b0}}, sa};
    eb     = {{(DW+1){1'b0}}, sb};
    ec     = {{(DW+1){1'b0}}, sc};
    sq_sum = ea * ea + eb * eb;
    sq_c   = ec * ec;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sa       <= '0;
      sb       <= '0;
      sc       <= '0;
      is_tri_q <= 1'b0;
      eq_ab_q  <= 1'b0;
      eq_bc_q  <= 1'b0;
      eq_ac_q  <= 1'b0;
      right_q  <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          sa <= lo0;
          sb <= lo1;
          sc <= mx;
        end
        ST_CHK: begin
          is_tri_q <= (sa != '0) && (sb != '0) && (sc != '0) && (sum_ab > {1'b0, sc});
          eq_ab_q  <= (sa == sb);
          eq_bc_q  <= (sb == sc);
          eq_ac_q  <= (sa == sc);
        end
        ST_SQ:   right_q <= is_tri_q && (sq_sum == sq_c);
        default: ;
      endcase
    end
  end

  always_comb begin
    kind = KIND_SCALENE;
    if (eq_ab_q && eq_bc_q)                kind = KIND_EQUI;
    else if (eq_ab_q || eq_bc_q || eq_ac_q) kind = KIND_ISO;
  end

  always_comb begin
    done   = (state == ST_DONE);
    result = '0;
    if (is_tri_q) begin
      result[RES_TRI_BIT]                = 1'b1;
      result[RES_KIND_MSB:RES_KIND_LSB]  = kind;
      result[RES_RIGHT_BIT]              = right_q;
    end
  end

endmodule

// File: rtl/avalon_tri_classify.sv
// Avalon-MM slave with NCH side-triple channels; RESULT reads of a dirty
// channel stall on waitrequest while the shared engine recomputes.
module avalon_tri_classify
  import avalon_tri_pkg::*;
#(
  parameter int DW  = 32,
  parameter int NCH = 4,
  parameter int AW  = $clog2(NCH) + 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] address,
  input  logic          read,
  input  logic          write,
  input  logic [DW-1:0] writedata,
  output logic          waitrequest,
  output logic [DW-1:0] readdata
);

  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic [CHW-1:0] ch, pend_ch;
  logic [1:0]     reg_sel;
  logic [DW-1:0]  side_a [NCH];
  logic [DW-1:0]  side_b [NCH];
  logic [DW-1:0]  side_c [NCH];
  logic [3:0]     result_q [NCH];
  logic [NCH-1:0] dirty;
  logic           busy;
  logic           core_start, core_done;
  logic [3:0]     core_result;
  logic [DW-1:0]  side_word, stored_word, core_word;

  assign reg_sel = address[1:0];

  generate
    if (NCH > 1) begin : g_chan
      assign ch = address[AW-1:2];
    end else begin : g_single
      assign ch = '0;
    end
  endgenerate

  assign core_start = !busy && waitrequest && read && !write &&
                      (reg_sel == REG_RESULT) && dirty[ch];

  always_comb begin
    side_word   = '0;
    stored_word = '0;
    core_word   = '0;
    stored_word[3:0] = result_q[ch];
    core_word[3:0]   = core_result;
    case (reg_sel)
      REG_A:   side_word = side_a[ch];
      REG_B:   side_word = side_b[ch];
      REG_C:   side_word = side_c[ch];
      default: side_word = '0;
    endcase
  end

  // A request is sampled only while idle; waitrequest is low for one cycle per accepted transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      waitrequest <= 1'b1;
      readdata    <= '0;
      dirty       <= '0;
      busy        <= 1'b0;
      pend_ch     <= '0;
      for (int i = 0; i < NCH; i++) begin
        side_a[i]   <= '0;
        side_b[i]   <= '0;
        side_c[i]   <= '0;
        result_q[i] <= '0;
      end
    end else begin
      waitrequest <= 1'b1;
      readdata    <= '0;
      if (write && !waitrequest) begin
        case (reg_sel)
          REG_A: begin side_a[ch] <= writedata; dirty[ch] <= 1'b1; end
          REG_B: begin side_b[ch] <= writedata; dirty[ch] <= 1'b1; end
          REG_C: begin side_c[ch] <= writedata; dirty[ch] <= 1'b1; end
          default: ;
        endcase
      end
      if (busy) begin
        if (core_done) begin
          result_q[pend_ch] <= core_result;
          dirty[pend_ch]    <= 1'b0;
          readdata          <= core_word;
          waitrequest       <= 1'b0;
          busy              <= 1'b0;
        end
      end else if (waitrequest && (read || write)) begin
        if (write) begin
          waitrequest <= 1'b0;
        end else if (reg_sel != REG_RESULT) begin
          waitrequest <= 1'b0;
          readdata    <= side_word;
        end else if (!dirty[ch]) begin
          waitrequest <= 1'b0;
          readdata    <= stored_word;
        end else begin
          busy    <= 1'b1;
          pend_ch <= ch;
        end
      end
    end
  end

  tri_class_core #(.DW(DW)) u_core (
    .clk    (clk),
    .reset  (reset),
    .start  (core_start),
    .a      (side_a[pend_ch]),
    .b      (side_b[pend_ch]),
    .c      (side_c[pend_ch]),
    .done   (core_done),
    .result (core_result)
  );

endmodule

// File: tb/tb_avalon_tri_classify.sv
// Directed bench for avalon_tri_classify: a geometric model predicts every
// acknowledged read and the handshake latency of each transfer.
module tb_avalon_tri_classify;
  import avalon_tri_pkg::*;

  localparam int DW  = 32;
  localparam int NCH = 4;
  localparam int AW  = $clog2(NCH) + 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] address;
  logic          read;
  logic          write;
  logic [DW-1:0] writedata;
  logic          waitrequest;
  logic [DW-1:0] readdata;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] m_side [NCH][3];
  bit            m_dirty [NCH];
  bit            exp_read_pending  = 1'b0;
  bit            exp_write_pending = 1'b0;
  logic [DW-1:0] exp_data = '0;

  always #5 clk = ~clk;

  avalon_tri_classify #(.DW(DW), .NCH(NCH)) dut (
    .clk         (clk),
    .reset       (reset),
    .address     (address),
    .read        (read),
    .write       (write),
    .writedata   (writedata),
    .waitrequest (waitrequest),
    .readdata    (readdata)
  );

  // Classify by the triangle inequality on every pair and Pythagoras on every permutation.
  function automatic logic [DW-1:0] model_classify(input logic [DW-1:0] x, y, z);
    logic [127:0]  X, Y, Z;
    logic [DW-1:0] r;
    bit            is_tri, right;
    int            eq;
    X = 128'(x);
    Y = 128'(y);
    Z = 128'(z);
    r = '0;
    is_tri = (x != 0) && (y != 0) && (z != 0) && (X + Y > Z) && (X + Z > Y) && (Y + Z > X);
    right  = (X*X + Y*Y == Z*Z) || (X*X + Z*Z == Y*Y) || (Y*Y + Z*Z == X*X);
    eq     = int'(x == y) + int'(y == z) + int'(x == z);
    if (is_tri) begin
      r[0]   = 1'b1;
      r[2:1] = (eq == 3) ? 2'd3 : (eq >= 1) ? 2'd2 : 2'd1;
      r[3]   = right;
    end
    return r;
  endfunction

  task automatic check_output(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Every acknowledged read must carry the model's value; idle cycles must keep waitrequest high.
  always @(negedge clk) begin
    if (exp_read_pending && !waitrequest)
      check_output("readdata", readdata, exp_data);
    else if (!exp_read_pending && !exp_write_pending)
      check_output("idle_waitrequest", {{(DW-1){1'b0}}, waitrequest}, 1);
  end

  task automatic apply_stimulus(input bit do_rd, input bit do_wr, input int ch, input int rg,
                                input logic [DW-1:0] data, input int exp_lat,
                                input logic [DW-1:0] exp_rd, input string name);
    int lat;
    @(negedge clk);
    exp_data          = exp_rd;
    exp_read_pending  = do_rd && !do_wr;
    exp_write_pending = do_wr;
    address   = {ch[AW-3:0], rg[1:0]};
    read      = do_rd;
    write     = do_wr;
    writedata = data;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (waitrequest && lat < 20);
    check_output({name, "_latency"}, lat, exp_lat);
    @(posedge clk);
    #1;
    read  = 1'b0;
    write = 1'b0;
    exp_read_pending  = 1'b0;
    exp_write_pending = 1'b0;
  endtask

  task automatic write_side(input int ch, input int rg, input logic [DW-1:0] v);
    apply_stimulus(1'b0, 1'b1, ch, rg, v, 1, '0, "write_side");
    m_side[ch][rg] = v;
    m_dirty[ch]    = 1'b1;
  endtask

  task automatic write_tri(input int ch, input logic [DW-1:0] x, y, z);
    write_side(ch, 0, x);
    write_side(ch, 1, y);
    write_side(ch, 2, z);
  endtask

  task automatic read_side(input int ch, input int rg);
    apply_stimulus(1'b1, 1'b0, ch, rg, '0, 1, m_side[ch][rg], "read_side");
  endtask

  task automatic read_result(input int ch, input logic [DW-1:0] literal);
    logic [DW-1:0] e;
    e = model_classify(m_side[ch][0], m_side[ch][1], m_side[ch][2]);
    check_output("model_pin", e, literal);
    apply_stimulus(1'b1, 1'b0, ch, 3, '0, m_dirty[ch] ? ENGINE_LAT : 1, e, "read_result");
    m_dirty[ch] = 1'b0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_dirty[i] = 1'b0;
      for (int j = 0; j < 3; j++) m_side[i][j] = '0;
    end
  endtask

  initial begin
    reset = 1'b1; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_output("reset_waitrequest", {{(DW-1){1'b0}}, waitrequest}, 1);
    check_output("reset_readdata", readdata, '0);
    reset = 1'b0;

    write_tri(0, 3, 4, 5);
    read_result(0, 32'hB);
    read_result(0, 32'hB);

    write_tri(1, 5, 5, 5);  read_result(1, 32'h7);
    write_tri(2, 2, 2, 3);  read_result(2, 32'h5);
    write_tri(3, 1, 2, 3);  read_result(3, 32'h0);
    write_tri(0, 0, 5, 5);  read_result(0, 32'h0);

    write_tri(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1);
    read_result(0, 32'h5);
    write_side(0, 2, 32'hFFFF_FFFE);
    read_result(0, 32'h5);
    read_side(0, 0);
    read_side(0, 2);

    write_tri(0, 3, 4, 5);
    write_tri(1, 6, 6, 6);
    read_result(1, 32'h7);
    read_result(0, 32'hB);
    write_side(0, 2, 6);
    read_result(0, 32'h3);
    read_result(1, 32'h7);

    apply_stimulus(1'b0, 1'b1, 1, 3, 32'hFFFF_FFFF, 1, '0, "write_result_reg");
    read_result(1, 32'h7);

    apply_stimulus(1'b1, 1'b1, 2, 0, 32'd7, 1, '0, "read_write_both");
    m_side[2][0] = 32'd7;
    m_dirty[2]   = 1'b1;
    read_side(2, 0);
    read_result(2, 32'h0);

    write_tri(3, 3, 4, 5);
    @(negedge clk);
    address = {2'd3, REG_RESULT};
    read    = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    read  = 1'b0;
    repeat (2) @(negedge clk);
    check_output("abort_readdata", readdata, '0);
    reset = 1'b0;
    model_reset();
    repeat (8) @(negedge clk);
    read_result(3, 32'h0);
    read_side(3, 0);
    read_side(3, 1);
    read_side(3, 2);
    read_side(0, 0);
    read_side(1, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
